can_tx_framer: RTL and testbench

- Downstream of the CAN register shell: on a TX_START pulse it takes TX_ID/TX_LEN/TX_DATA0/TX_DATA1 and serialises a CAN 2.0A base data frame onto `can_tx`.
- Implements the frame field sequence, CRC-15 and bit stuffing, with bit timing from a fixed clock divider.
- Replaces the shell's "instant TX_DONE" with a real completion pulse.

---
 rtl/can_tx_framer.sv | 171 +++++++++++++++++
 tb/tb_can_tx_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_framer.sv
// can_tx_framer: serialises a CAN 2.0A base data frame (SOF..IFS) with CRC-15 and bit stuffing.
// Optional: define CAN_TX_ACK_CHECK_EN to sample can_rx in the ACK slot and pulse ack_err on a missing ACK.
module can_tx_framer #(
  parameter int BIT_DIV   = 4,
  parameter int MAX_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [10:0] tx_id,
  input  logic [7:0]  tx_len,
  input  logic [7:0]  tx_data0,
  input  logic [7:0]  tx_data1,
  input  logic        can_rx,
  output logic        can_tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        ack_err
);

  localparam int              DW       = $clog2(BIT_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [3:0]      MAX_DLC  = 4'(MAX_BYTES);
  localparam logic [14:0]     CRC_POLY = 15'h4599;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC,
    ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF, ST_IFS
  } state_t;

  state_t        r_state, w_state_next;
  logic [DW-1:0] r_div;
  logic [3:0]    r_bit_cnt;
  logic [10:0]   r_id;
  logic [3:0]    r_dlc;
  logic [15:0]   r_data;
  logic [14:0]   r_crc;
  logic [2:0]    r_run;
  logic          r_last;
  logic          r_stuff;

  logic          w_tick;
  logic          w_bit;
  logic          w_field_end;
  logic          w_crc_zone;
  logic          w_stuff_zone;
  logic [3:0]    w_field_last;
  logic [11:0]   w_arb;
  logic [5:0]    w_ctrl;
  logic [2:0]    w_run_next;
  logic [14:0]   w_crc_next;

  assign w_tick       = (r_div == DIV_LAST);
  assign w_arb        = {r_id, 1'b0};
  assign w_ctrl       = {2'b00, r_dlc};
  assign w_crc_zone   = r_state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA};
  assign w_stuff_zone = w_crc_zone || (r_state == ST_CRC);

  // NOTE: combinational blocks assign every output a default first so no path infers a latch.
  always_comb begin
    w_bit        = 1'b1;
    w_field_last = 4'd0;
    case (r_state)
      ST_SOF:  w_bit = 1'b0;
      ST_ARB:  begin w_bit = w_arb[4'd11 - r_bit_cnt];       w_field_last = 4'd11; end
      ST_CTRL: begin w_bit = w_ctrl[3'd5 - r_bit_cnt[2:0]];  w_field_last = 4'd5;  end
      // DATA is only entered with one or two bytes, so the last index is 7 or 15.
      ST_DATA: begin w_bit = r_data[4'd15 - r_bit_cnt];      w_field_last = {r_dlc[1], 3'b111}; end
      ST_CRC:  begin w_bit = r_crc[4'd14 - r_bit_cnt];       w_field_last = 4'd14; end
      ST_EOF:  w_field_last = 4'd6;
      ST_IFS:  w_field_last = 4'd2;
      default: ;
    endcase
  end

  // A pending stuff bit occupies a full bit slot without advancing the field counter.
  assign w_field_end = w_tick && !r_stuff && (r_bit_cnt == w_field_last);
  assign can_tx      = r_stuff ? ~r_last : w_bit;
  assign tx_busy     = (r_state != ST_IDLE);
  assign tx_done     = (r_state == ST_IFS) && w_field_end;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE) begin
      if (tx_start) w_state_next = ST_SOF;
    end else if (w_field_end) begin
      case (r_state)
        ST_SOF:     w_state_next = ST_ARB;
        ST_ARB:     w_state_next = ST_CTRL;
        ST_CTRL:    w_state_next = (r_dlc == 4'd0) ? ST_CRC : ST_DATA;
        ST_DATA:    w_state_next = ST_CRC;
        ST_CRC:     w_state_next = ST_CRC_DEL;
        ST_CRC_DEL: w_state_next = ST_ACK;
        ST_ACK:     w_state_next = ST_ACK_DEL;
        ST_ACK_DEL: w_state_next = ST_EOF;
        ST_EOF:     w_state_next = ST_IFS;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_run_next = (w_bit == r_last) ? r_run + 3'd1 : 3'd1;
  assign w_crc_next = {r_crc[13:0], 1'b0} ^ ((w_bit ^ r_crc[14]) ? CRC_POLY : 15'd0);

  // NOTE: no memories here, so every register takes the async reset and the bus releases at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_bit_cnt <= 4'd0;
      r_id      <= 11'd0;
      r_dlc     <= 4'd0;
      r_data    <= 16'd0;
      r_crc     <= 15'd0;
      r_run     <= 3'd0;
      r_last    <= 1'b1;
      r_stuff   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_div     <= '0;
      r_bit_cnt <= 4'd0;
      r_crc     <= 15'd0;
      r_run     <= 3'd0;
      r_last    <= 1'b1;
      r_stuff   <= 1'b0;
      if (tx_start) begin
        r_id   <= tx_id;
        r_dlc  <= (tx_len > 8'(MAX_BYTES)) ? MAX_DLC : tx_len[3:0];
        r_data <= {tx_data0, tx_data1};
      end
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        if (r_stuff) begin
          // The stuff bit starts the next run of identical bits.
          r_stuff <= 1'b0;
          r_last  <= ~r_last;
          r_run   <= 3'd1;
        end else begin
          r_last    <= w_bit;
          r_run     <= w_run_next;
          r_stuff   <= w_stuff_zone && (w_run_next == 3'd5);
          r_bit_cnt <= (r_bit_cnt == w_field_last) ? 4'd0 : r_bit_cnt + 4'd1;
          if (w_crc_zone) r_crc <= w_crc_next;
        end
      end
    end
  end

`ifdef CAN_TX_ACK_CHECK_EN
  localparam logic [DW-1:0] DIV_MID = DW'(BIT_DIV / 2);
  logic r_ack_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_ack_miss <= 1'b0;
    else if (r_state == ST_IDLE)                       r_ack_miss <= 1'b0;
    else if ((r_state == ST_ACK) && (r_div == DIV_MID)) r_ack_miss <= can_rx;
  end

  assign ack_err = r_ack_miss && (r_state == ST_ACK_DEL) && w_field_end;
`else
  logic w_unused_can_rx;
  assign w_unused_can_rx = can_rx;
  assign ack_err         = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_framer.sv
// Directed bench for can_tx_framer: table of frames checked against a software CAN frame builder,
// plus hand-written reset-abort and idle sequences.
`timescale 1ns/1ps
module tb_can_tx_framer;
  localparam int BIT_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [10:0] tx_id = 11'd0;
  logic [7:0]  tx_len = 8'd0;
  logic [7:0]  tx_data0 = 8'd0;
  logic [7:0]  tx_data1 = 8'd0;
  logic        can_rx = 1'b1;
  logic        can_tx, tx_busy, tx_done, ack_err;

  can_tx_framer #(.BIT_DIV(BIT_DIV), .MAX_BYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_id(tx_id), .tx_len(tx_len),
    .tx_data0(tx_data0), .tx_data1(tx_data1), .can_rx(can_rx),
    .can_tx(can_tx), .tx_busy(tx_busy), .tx_done(tx_done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] id;
    logic [7:0]  len;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        ack_rx;
    logic [3:0]  exp_dlc;
    int          exp_bits;       // hand-counted SOF..IFS bits, 0 when not hand-counted
    logic        mid_start;
    logic        start_at_done;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_err = 0;

  logic        m_bits[0:255];
  int          m_len;
  int          m_ls;
  int          m_nraw;
  logic [14:0] m_crc;
  logic        cap[0:255];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  // Software frame builder: unstuffed field list, CRC-15, then stuffing and the recessive tail.
  task automatic build_model(input logic [10:0] id, input logic [7:0] len,
                             input logic [7:0] d0, input logic [7:0] d1);
    logic       raw[$];
    logic [3:0] dlc4;
    logic [15:0] dat;
    logic       last;
    logic       fb;
    int         run;
    dlc4 = (len > 8'd2) ? 4'd2 : len[3:0];
    dat  = {d0, d1};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    repeat (3) raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc4[i]);
    for (int i = 0; i < 8 * int'(dlc4); i++) raw.push_back(dat[15 - i]);
    m_crc = 15'd0;
    foreach (raw[i]) begin
      fb    = raw[i] ^ m_crc[14];
      m_crc = {m_crc[13:0], 1'b0};
      if (fb) m_crc = m_crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(m_crc[i]);
    m_nraw = raw.size();
    m_len  = 0;
    run    = 0;
    last   = 1'b1;
    foreach (raw[i]) begin
      m_bits[m_len] = raw[i];
      m_len++;
      run  = (raw[i] == last) ? run + 1 : 1;
      last = raw[i];
      if (run == 5) begin
        m_bits[m_len] = ~last;
        m_len++;
        last = ~last;
        run  = 1;
      end
    end
    m_ls = m_len;
    repeat (13) begin
      m_bits[m_len] = 1'b1;
      m_len++;
    end
  endtask

  // Removes stuff bits from the captured DUT stream and pulls out the DLC and CRC fields.
  task automatic destuff(output logic [3:0] dlc, output logic [14:0] crc);
    logic raw[$];
    int   idx = 0;
    int   run = 0;
    logic last = 1'b1;
    while (raw.size() < m_nraw && idx < 255) begin
      raw.push_back(cap[idx]);
      run  = (cap[idx] === last) ? run + 1 : 1;
      last = cap[idx];
      idx++;
      if (run == 5) begin
        last = cap[idx];
        run  = 1;
        idx++;
      end
    end
    while (raw.size() < m_nraw) raw.push_back(1'bx);
    dlc = {raw[15], raw[16], raw[17], raw[18]};
    for (int i = 0; i < 15; i++) crc[14 - i] = raw[m_nraw - 15 + i];
  endtask

  task automatic run_frame(input vec_t v);
    int          done_k, n_done, ack_k, n_ack, busy_bad, stream_bad, limit, exp_ack_k, bi;
    logic        exp_bit;
    logic [3:0]  dut_dlc;
    logic [14:0] dut_crc;
    build_model(v.id, v.len, v.d0, v.d1);
    for (int i = 0; i < 256; i++) cap[i] = 1'bx;
    limit  = m_len * BIT_DIV + 6;
    done_k = -1; n_done = 0; ack_k = -1; n_ack = 0; busy_bad = 0; stream_bad = 0;
    @(negedge clk);
    can_rx   = v.ack_rx;
    tx_id    = v.id;
    tx_len   = v.len;
    tx_data0 = v.d0;
    tx_data1 = v.d1;
    tx_start = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      bi      = (k - 1) / BIT_DIV;
      exp_bit = (bi < m_len) ? m_bits[bi] : 1'b1;
      if (can_tx !== exp_bit) stream_bad++;
      if ((k - 1) % BIT_DIV == BIT_DIV / 2) cap[bi] = can_tx;
      if (tx_done === 1'b1) begin n_done++; if (done_k < 0) done_k = k; end
      if (ack_err === 1'b1) begin n_ack++;  if (ack_k < 0)  ack_k  = k; end
      if (tx_busy !== (k <= m_len * BIT_DIV)) busy_bad++;
      if (k == 1) tx_start = 1'b0;
      if (v.mid_start && k == 30) begin tx_start = 1'b1; tx_id = 11'h555; tx_len = 8'd1; end
      if (v.mid_start && k == 31) tx_start = 1'b0;
      if (v.start_at_done && k == m_len * BIT_DIV)     tx_start = 1'b1;
      if (v.start_at_done && k == m_len * BIT_DIV + 1) tx_start = 1'b0;
    end
    check("stream_mismatches", stream_bad, 0);
    check("busy_mismatches", busy_bad, 0);
    check("done_cycle", done_k, m_len * BIT_DIV);
    check("done_count", n_done, 1);
    if (v.exp_bits != 0) check("done_cycle_hand", done_k, v.exp_bits * BIT_DIV);
    destuff(dut_dlc, dut_crc);
    check("dlc_field", dut_dlc, v.exp_dlc);
    check("crc_field", dut_crc, m_crc);
`ifdef CAN_TX_ACK_CHECK_EN
    exp_ack_k = v.ack_rx ? (m_ls + 3) * BIT_DIV : -1;
    check("ack_err_count", n_ack, v.ack_rx ? 1 : 0);
`else
    exp_ack_k = -1;
`endif
    check("ack_err_cycle", ack_k, exp_ack_k);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          id       len    d0     d1     ack   dlc   bits mid   done
    vecs[0] = '{11'h000, 8'd0, 8'h00, 8'h00, 1'b0, 4'd0, 53, 1'b0, 1'b0};
    vecs[1] = '{11'h7FF, 8'd0, 8'h00, 8'h00, 1'b0, 4'd0, 0,  1'b0, 1'b1};
    vecs[2] = '{11'h123, 8'd2, 8'hA5, 8'h3C, 1'b1, 4'd2, 0,  1'b0, 1'b0};
    vecs[3] = '{11'h456, 8'd9, 8'h5A, 8'hC3, 1'b0, 4'd2, 0,  1'b1, 1'b1};
    vecs[4] = '{11'h2AA, 8'd1, 8'hFF, 8'h00, 1'b1, 4'd1, 0,  1'b0, 1'b0};

    #1;
    check("reset_can_tx", can_tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_ack_err", ack_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
      if (i == 0) check("zero_run_stuff_bit5", cap[5], 1);
      if (i == 1) begin
        check("ones_run_stuff_bit6", cap[6], 0);
        check("ones_run_stuff_bit12", cap[12], 0);
      end
    end

    // Abort during the DATA field of a two-byte frame, then send a full frame.
    @(negedge clk);
    tx_id = 11'h123; tx_len = 8'd2; tx_data0 = 8'hA5; tx_data1 = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (92) @(negedge clk);
    check("abort_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_can_tx", can_tx, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_done", tx_done, 0);
    repeat (2) @(negedge clk);
    check("abort_can_tx_held", can_tx, 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
